// File: rtl/csr_pkg.sv
// Shared CSR definitions for the FPU control/status register path:
// addresses, access-op encodings and the arbiter FSM state type.
package csr_pkg;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    localparam logic [1:0] OP_RW = 2'b00;
    localparam logic [1:0] OP_RS = 2'b01;
    localparam logic [1:0] OP_RC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INS  = 2'd1,
        ST_RESP = 2'd2,
        ST_FLAG = 2'd3
    } state_e;

endpackage

// File: rtl/fcsr_arbiter.sv
// Arbitrates the single CSR-file port between instruction accesses and
// accumulated FPU exception flags, alternating fairly under continuous flags.
module fcsr_arbiter
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ins_valid,
    input  logic [11:0]     i_ins_addr,
    input  logic [1:0]      i_ins_op,
    input  logic            i_ins_write,
    input  logic [XLEN-1:0] i_ins_wdata,
    output logic            o_ins_ready,
    output logic            o_ins_rvalid,
    output logic [XLEN-1:0] o_ins_rdata,
    input  logic            i_flag_valid,
    input  logic [4:0]      i_flags,
    output logic [11:0]     o_csr_addr,
    output logic [1:0]      o_csr_op,
    output logic            o_csr_write,
    output logic [XLEN-1:0] o_csr_wdata,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic            o_idle
);

    state_e            state_q, state_d;
    logic [4:0]        pend_q, pend_d;
    logic              prio_q, prio_d;
    logic [11:0]       addr_q, addr_d;
    logic [1:0]        op_q, op_d;
    logic              write_q, write_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [4:0]        flag_in;
    logic [4:0]        pend_acc;
    logic              hs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            op_q    <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        flag_in     = i_flag_valid ? i_flags : 5'd0;
        pend_acc    = pend_q | flag_in;
        o_ins_ready = (state_q == ST_IDLE) && ((pend_q == 5'd0) || prio_q);
        hs          = i_ins_valid && o_ins_ready;

        state_d     = state_q;
        pend_d      = pend_acc;
        prio_d      = prio_q;
        addr_d      = addr_q;
        op_d        = op_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        o_csr_addr  = '0;
        o_csr_op    = '0;
        o_csr_write = 1'b0;
        o_csr_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    addr_d  = i_ins_addr;
                    op_d    = i_ins_op;
                    write_d = i_ins_write;
                    wdata_d = i_ins_wdata;
                    prio_d  = 1'b0;
                    state_d = ST_INS;
                end else begin
                    if (!i_ins_valid) prio_d = 1'b0;
                    // Same-cycle strobes count, so the flag write lands one cycle after arrival.
                    if (pend_acc != 5'd0) state_d = ST_FLAG;
                end
            end
            ST_INS: begin
                o_csr_addr  = addr_q;
                o_csr_op    = op_q;
                o_csr_write = write_q;
                o_csr_wdata = wdata_q;
                rdata_d     = i_csr_rdata;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_FLAG: begin
                o_csr_addr  = CSR_FFLAGS;
                o_csr_op    = OP_RS;
                o_csr_write = 1'b1;
                o_csr_wdata = {{(XLEN-5){1'b0}}, pend_q};
                pend_d      = flag_in;
                prio_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ins_rvalid = (state_q == ST_RESP);
    assign o_ins_rdata  = rdata_q;
    assign o_idle       = (state_q == ST_IDLE) && (pend_q == 5'd0);

endmodule

// File: tb/tb_fcsr_arbiter.sv
// Directed bench for fcsr_arbiter with a behavioural fflags/frm CSR file
// attached to the CSR port; expected values are hand-derived per scenario.
module tb_fcsr_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            ins_valid;
    logic [11:0]     ins_addr;
    logic [1:0]      ins_op;
    logic            ins_write;
    logic [XLEN-1:0] ins_wdata;
    logic            ins_ready;
    logic            ins_rvalid;
    logic [XLEN-1:0] ins_rdata;
    logic            flag_valid;
    logic [4:0]      flags;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic            csr_write;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            idle;

    int unsigned n_chk;
    int unsigned n_pass;

    fcsr_arbiter #(.XLEN(XLEN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ins_valid  (ins_valid),
        .i_ins_addr   (ins_addr),
        .i_ins_op     (ins_op),
        .i_ins_write  (ins_write),
        .i_ins_wdata  (ins_wdata),
        .o_ins_ready  (ins_ready),
        .o_ins_rvalid (ins_rvalid),
        .o_ins_rdata  (ins_rdata),
        .i_flag_valid (flag_valid),
        .i_flags      (flags),
        .o_csr_addr   (csr_addr),
        .o_csr_op     (csr_op),
        .o_csr_write  (csr_write),
        .o_csr_wdata  (csr_wdata),
        .i_csr_rdata  (csr_rdata),
        .o_idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CSR file: fflags/frm with RW/RS/RC merging.
    logic [4:0] m_fflags;
    logic [2:0] m_frm;

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h001: csr_rdata = {27'd0, m_fflags};
            12'h002: csr_rdata = {29'd0, m_frm};
            12'h003: csr_rdata = {24'd0, m_frm, m_fflags};
            default: csr_rdata = '0;
        endcase
    end

    function automatic logic [7:0] merge(input logic [7:0] old, input logic [1:0] op,
                                         input logic [7:0] wd);
        case (op)
            2'b00:   merge = wd;
            2'b01:   merge = old | wd;
            2'b10:   merge = old & ~wd;
            default: merge = old;
        endcase
    endfunction

    logic [7:0] fcsr_new;
    always_comb fcsr_new = merge({m_frm, m_fflags}, csr_op, csr_wdata[7:0]);

    initial begin
        m_fflags = 5'd0;
        m_frm    = 3'd3;
    end

    always @(posedge clk) begin
        if (csr_write) begin
            case (csr_addr)
                12'h001: m_fflags <= merge({3'd0, m_fflags}, csr_op, csr_wdata[7:0]) & 8'h1f;
                12'h002: m_frm    <= 3'(merge({5'd0, m_frm}, csr_op, csr_wdata[7:0]));
                12'h003: begin
                    m_frm    <= fcsr_new[7:5];
                    m_fflags <= fcsr_new[4:0];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // One cycle: outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ins(input logic [11:0] a, input logic [1:0] op,
                             input logic wr, input logic [31:0] wd);
        ins_valid = 1'b1;
        ins_addr  = a;
        ins_op    = op;
        ins_write = wr;
        ins_wdata = wd;
    endtask

    task automatic ins_access(input string tag, input logic [11:0] a, input logic [1:0] op,
                              input logic wr, input logic [31:0] wd, input logic [31:0] exp);
        int unsigned cnt;
        drive_ins(a, op, wr, wd);
        cnt = 0;
        while (!ins_ready && cnt < 20) begin
            step();
            cnt++;
        end
        step();
        ins_valid = 1'b0;
        cnt = 0;
        while (!ins_rvalid && cnt < 10) begin
            step();
            cnt++;
        end
        check({tag, "_rvalid"}, 32'(ins_rvalid), 32'd1);
        check({tag, "_rdata"}, ins_rdata, exp);
        step();
    endtask

    int unsigned flag_writes;
    int unsigned accepts;
    int unsigned starve_err;
    int unsigned wdata_err;
    int unsigned wr_after_rst;
    logic        prev_flag_wr;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        ins_valid = 1'b0;
        ins_addr = '0;
        ins_op = '0;
        ins_write = 1'b0;
        ins_wdata = '0;
        flag_valid = 1'b0;
        flags = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_ready", 32'(ins_ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_rvalid", 32'(ins_rvalid), 32'd0);
        check("rst_rdata", ins_rdata, 32'd0);
        check("rst_csr_write", 32'(csr_write), 32'd0);

        // RW frm=5: write at N+1, rvalid with old frm (3) at N+2
        drive_ins(12'h002, 2'b00, 1'b1, 32'h5);
        check("rw_ready", 32'(ins_ready), 32'd1);
        step();
        ins_valid = 1'b0;
        check("rw_csr_write", 32'(csr_write), 32'd1);
        check("rw_csr_addr", 32'(csr_addr), 32'h002);
        check("rw_csr_op", 32'(csr_op), 32'd0);
        check("rw_csr_wdata", csr_wdata, 32'h5);
        check("rw_rvalid_n1", 32'(ins_rvalid), 32'd0);
        step();
        check("rw_rvalid_n2", 32'(ins_rvalid), 32'd1);
        check("rw_rdata_old", ins_rdata, 32'h3);
        check("rw_resp_nowrite", 32'(csr_write), 32'd0);
        step();
        check("rw_rvalid_n3", 32'(ins_rvalid), 32'd0);
        check("rw_rdata_hold", ins_rdata, 32'h3);
        ins_access("frm_read", 12'h002, 2'b01, 1'b0, 32'h0, 32'h5);

        // Flag strobe while idle
        flag_valid = 1'b1;
        flags = 5'h04;
        step();
        flag_valid = 1'b0;
        check("flag_ready0", 32'(ins_ready), 32'd0);
        check("flag_write", 32'(csr_write), 32'd1);
        check("flag_addr", 32'(csr_addr), 32'h001);
        check("flag_op", 32'(csr_op), 32'd1);
        check("flag_wdata", csr_wdata, 32'h04);
        step();
        check("flag_done_idle", 32'(idle), 32'd1);
        check("flag_done_write", 32'(csr_write), 32'd0);
        ins_access("fflags_read1", 12'h001, 2'b01, 1'b0, 32'h0, 32'h04);
        ins_access("fflags_clr1", 12'h001, 2'b00, 1'b1, 32'h0, 32'h04);

        // Flags 0x01 (INS) and 0x10 (RESP) merge into one FLAG write after RESP
        drive_ins(12'h002, 2'b01, 1'b0, 32'h0);
        step();
        ins_valid = 1'b0;
        flag_valid = 1'b1;
        flags = 5'h01;
        check("mrg_in_ins", 32'(csr_addr), 32'h002);
        step();
        flags = 5'h10;
        check("mrg_rvalid", 32'(ins_rvalid), 32'd1);
        step();
        flag_valid = 1'b0;
        check("mrg_idle_ready0", 32'(ins_ready), 32'd0);
        check("mrg_idle_nowrite", 32'(csr_write), 32'd0);
        step();
        check("mrg_flag_write", 32'(csr_write), 32'd1);
        check("mrg_flag_wdata", csr_wdata, 32'h11);
        flag_writes = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (csr_write) flag_writes++;
        end
        check("mrg_once", flag_writes, 32'd0);
        ins_access("fflags_read2", 12'h001, 2'b01, 1'b0, 32'h0, 32'h11);
        ins_access("fflags_clr2", 12'h001, 2'b00, 1'b1, 32'h0, 32'h11);

        // Continuous 0x02 flags with instruction held: alternation, no starvation
        drive_ins(12'h002, 2'b01, 1'b0, 32'h0);
        flag_valid = 1'b1;
        flags = 5'h02;
        flag_writes = 0;
        accepts = 0;
        starve_err = 0;
        wdata_err = 0;
        prev_flag_wr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (prev_flag_wr && !ins_ready) starve_err++;
            if (ins_rvalid) accepts++;
            prev_flag_wr = 1'b0;
            if (csr_write && csr_addr == 12'h001) begin
                flag_writes++;
                prev_flag_wr = 1'b1;
                if (csr_wdata != 32'h02) wdata_err++;
            end
            step();
        end
        ins_valid = 1'b0;
        flags = 5'h08;
        step();
        flag_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("cont_starve", starve_err, 32'd0);
        check("cont_wdata", wdata_err, 32'd0);
        check("cont_accepts", 32'(accepts >= 8), 32'd1);
        check("cont_flagwr", 32'(flag_writes >= 8), 32'd1);
        check("cont_idle", 32'(idle), 32'd1);
        ins_access("fflags_read3", 12'h001, 2'b01, 1'b0, 32'h0, 32'h0a);

        // Reset during INS aborts the write and drops a pending flag
        drive_ins(12'h002, 2'b00, 1'b1, 32'h7);
        step();
        ins_valid = 1'b0;
        flag_valid = 1'b1;
        flags = 5'h01;
        check("rstins_in_ins", 32'(csr_write), 32'd1);
        rst_n = 1'b0;
        #1;
        flag_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        wr_after_rst = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (csr_write) wr_after_rst++;
        end
        check("rstins_nowrite", wr_after_rst, 32'd0);
        check("rstins_rvalid", 32'(ins_rvalid), 32'd0);
        check("rstins_idle", 32'(idle), 32'd1);
        check("rstins_ready", 32'(ins_ready), 32'd1);
        check("rstins_rdata", ins_rdata, 32'd0);
        ins_access("rstins_frm", 12'h002, 2'b01, 1'b0, 32'h0, 32'h5);

        // CSRRS x0 on FCSR: read-only, {frm,fflags}
        drive_ins(12'h003, 2'b01, 1'b0, 32'h0);
        step();
        ins_valid = 1'b0;
        check("fcsr_nowrite", 32'(csr_write), 32'd0);
        check("fcsr_addr", 32'(csr_addr), 32'h003);
        step();
        check("fcsr_rvalid", 32'(ins_rvalid), 32'd1);
        check("fcsr_rdata", ins_rdata, 32'h000000aa);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
